// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                   |
// | Description : Shared CPU definitions used by the serial add/sub ALU:    |
// |               ALU opcode values, ALU state encoding and word width.     |
// | Contents    : ALU_ADD / ALU_SUB  - alu_op values                        |
// |               alu_state_e        - ALU FSM states (IDLE, CALC, WAIT)    |
// |               WORD_W             - native datapath width                |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package cpu_pkg;

  // alu_op encoding. The sub opcode doubles as the initial carry-in,
  // because A - B is computed as A + ~B + 1.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Native CPU word width
  localparam int WORD_W = 16;

  // ALU sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WAIT = 2'd2
  } alu_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/alu_digit_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_digit_adder                                           |
// | Description : Combinational DIGIT-bit ripple adder slice used by the    |
// |               serial ALU. One slice is reused every CALC cycle.          |
// | Ports       : i_a, i_b        DIGIT-bit operand digits                  |
// |               i_cin           carry into bit 0 of the digit             |
// |               o_sum           DIGIT-bit sum digit                       |
// |               o_cout          carry out of the digit MSB                |
// |               o_msb_carry_in  carry into the digit MSB (cin ^ cout of   |
// |                               the top digit is the signed overflow)     |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module alu_digit_adder
  import cpu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_msb_carry_in
);

  logic [DIGIT:0] w_total;

  always_comb begin
    w_total = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
  end

  assign o_sum  = w_total[DIGIT-1:0];
  assign o_cout = w_total[DIGIT];

  // sum = a ^ b ^ carry_in at every bit, so the carry into the MSB
  // can be recovered from the MSB sum bit without a second adder.
  assign o_msb_carry_in = i_a[DIGIT-1] ^ i_b[DIGIT-1] ^ w_total[DIGIT-1];

endmodule : alu_digit_adder
`default_nettype wire

// File: rtl/serial_alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : serial_alu                                                |
// | Description : Multi-cycle add/sub ALU. Operands are latched on the      |
// |               start edge, then DIGIT bits are summed per cycle, LSB     |
// |               first, through a single narrow adder slice. The result    |
// |               and flags are loaded together on the last CALC edge and   |
// |               alu_done pulses for exactly one cycle.                    |
// | Ports       : clk, reset (sync, active-high)                            |
// |               alu_start   level request, sampled only in IDLE           |
// |               alu_op      0 = add, 1 = sub (rs1 - operand B)            |
// |               immediate   1 selects sgnext_imm as operand B             |
// |               rs1_data, rs2_data, sgnext_imm  operands                  |
// |               alu_result  registered result, held until next completion |
// |               alu_done    one-cycle completion pulse                    |
// |               flag_zero / flag_carry / flag_ovf  result flags           |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module serial_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_start,
  input  logic             alu_op,
  input  logic             immediate,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] sgnext_imm,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_done,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int N_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(N_DIGITS - 1);

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_alu: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  alu_state_e       r_state;
  alu_state_e       w_state_next;

  logic [WIDTH-1:0] r_a;        // operand A, shifted right one digit per CALC
  logic [WIDTH-1:0] r_b;        // operand B (already inverted for sub), shifted
  logic             r_a_msb;    // sign of A, kept for the overflow rule
  logic             r_b_msb;    // sign of the B actually added (post inversion)
  logic             r_carry;    // inter-digit carry; seeded with alu_op
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_partial;  // sum digits enter from the MSB side

  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_zero;
  logic             r_carry_flag;
  logic             r_ovf;

  // ------------------------------------------------------------------
  // Control decode
  // ------------------------------------------------------------------
  logic             w_load;
  logic             w_finish;

  // ------------------------------------------------------------------
  // Datapath wires
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] w_b_sel;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_partial_next;
  logic             w_ovf_rule;

  assign w_b_sel = immediate ? sgnext_imm : rs2_data;

  alu_digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .i_a            (r_a[DIGIT-1:0]),
    .i_b            (r_b[DIGIT-1:0]),
    .i_cin          (r_carry),
    .o_sum          (w_sum),
    .o_cout         (w_cout),
    .o_msb_carry_in (w_msb_cin)
  );

  // After N shifts the first digit has travelled down to bit 0, so the
  // value present on the last CALC edge is the complete result.
  assign w_partial_next = (r_partial >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));

  // Because B was inverted for sub, "signs of A and the added B agree and
  // the result sign differs" covers both the add and the sub overflow rules.
  assign w_ovf_rule = (r_a_msb == r_b_msb) && (w_partial_next[WIDTH-1] != r_a_msb);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and control strobes
  // ------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (alu_start) begin
          w_load       = 1'b1;
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == c_last_cnt) begin
          w_finish     = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A start level held past completion must not retrigger.
        if (!alu_start) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      r_partial    <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_zero       <= 1'b0;
      r_carry_flag <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_a       <= rs1_data;
        r_b       <= (alu_op == ALU_SUB) ? ~w_b_sel : w_b_sel;
        r_a_msb   <= rs1_data[WIDTH-1];
        r_b_msb   <= (alu_op == ALU_SUB) ? ~w_b_sel[WIDTH-1] : w_b_sel[WIDTH-1];
        r_carry   <= alu_op;
        r_cnt     <= '0;
        r_partial <= '0;
      end else if (r_state == ST_CALC) begin
        r_a       <= r_a >> DIGIT;
        r_b       <= r_b >> DIGIT;
        r_carry   <= w_cout;
        r_cnt     <= r_cnt + CNT_W'(1);
        r_partial <= w_partial_next;
        if (w_finish) begin
          r_result     <= w_partial_next;
          r_carry_flag <= w_cout;
          r_zero       <= (w_partial_next == '0);
          r_ovf        <= w_ovf_rule;
          r_done       <= 1'b1;
          // Sign-rule overflow must agree with carry-in/carry-out of the MSB.
          assert (w_ovf_rule == (w_msb_cin ^ w_cout));
        end
      end
    end
  end

  assign alu_result = r_result;
  assign alu_done   = r_done;
  assign flag_zero  = r_zero;
  assign flag_carry = r_carry_flag;
  assign flag_ovf   = r_ovf;

endmodule : serial_alu
`default_nettype wire

// File: tb/tb_serial_alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_serial_alu                                             |
// | Description : Self-checking bench for serial_alu. Directed cases plus   |
// |               randomized operations compared against an arithmetic      |
// |               reference model; checks done timing, result stability,   |
// |               held-start behaviour and mid-operation reset.             |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_serial_alu;
  import cpu_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         alu_start;
  logic         alu_op;
  logic         immediate;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic [W-1:0] sgnext_imm;
  logic [W-1:0] alu_result;
  logic         alu_done;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] last_res;

  serial_alu #(
    .WIDTH (W),
    .DIGIT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .immediate  (immediate),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .sgnext_imm (sgnext_imm),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic op,
                                output logic [15:0] r, output logic c, output logic z,
                                output logic v);
    int unsigned ua, ub, ut;
    int          sa, sb, t;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (op == ALU_ADD) begin
      ut = ua + ub;
      c  = (ut > 32'h0000_FFFF);
      t  = sa + sb;
    end else begin
      ut = ua - ub;
      c  = (ua >= ub);
      t  = sa - sb;
    end
    r = ut[15:0];
    z = (r == 16'h0000);
    v = (t > 32767) || (t < -32768);
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b2,
                        input logic [15:0] imm_v, input logic use_imm, input logic op,
                        input int hold, input bit scramble);
    logic [15:0] er;
    logic        ec, ez, ev;
    model(a, use_imm ? imm_v : b2, op, er, ec, ez, ev);
    @(negedge clk);
    rs1_data   = a;
    rs2_data   = b2;
    sgnext_imm = imm_v;
    immediate  = use_imm;
    alu_op     = op;
    alu_start  = 1'b1;
    @(posedge clk);  // sampling edge E0
    #1;
    if (scramble) begin
      rs1_data   = 16'($urandom);
      rs2_data   = 16'($urandom);
      sgnext_imm = 16'($urandom);
      immediate  = 1'($urandom);
      alu_op     = 1'($urandom);
    end
    for (int k = 1; k <= N; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s.done_e%0d", tag, k), alu_done, (k == N));
      if (k < N) chk($sformatf("%s.hold_res_e%0d", tag, k), alu_result, last_res);
    end
    chk({tag, ".result"}, alu_result, er);
    chk({tag, ".carry"}, flag_carry, ec);
    chk({tag, ".zero"}, flag_zero, ez);
    chk({tag, ".ovf"}, flag_ovf, ev);
    last_res = er;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s.held_done%0d", tag, h), alu_done, 0);
      chk($sformatf("%s.held_res%0d", tag, h), alu_result, er);
    end
    @(negedge clk);
    alu_start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".idle_done"}, alu_done, 0);
  endtask

  initial begin
    logic [15:0] ra, rb, ri;
    logic [15:0] corners [5];
    corners[0] = 16'h0000;
    corners[1] = 16'h7FFF;
    corners[2] = 16'h8000;
    corners[3] = 16'hFFFF;
    corners[4] = 16'h0001;

    reset      = 1'b1;
    alu_start  = 1'b0;
    alu_op     = 1'b0;
    immediate  = 1'b0;
    rs1_data   = '0;
    rs2_data   = '0;
    sgnext_imm = '0;
    last_res   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.result", alu_result, 0);
    chk("rst.done", alu_done, 0);
    chk("rst.flags", {flag_zero, flag_carry, flag_ovf}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add",      16'h1234, 16'h0FF0, 16'h0000, 1'b0, ALU_ADD, 0, 1'b0);
    run_op("sub_brw",  16'h0005, 16'h0007, 16'h0000, 1'b0, ALU_SUB, 0, 1'b0);
    run_op("sub_nb",   16'h0007, 16'h0005, 16'h0000, 1'b0, ALU_SUB, 0, 1'b0);
    run_op("imm",      16'h0010, 16'hAAAA, 16'hFFFF, 1'b1, ALU_ADD, 0, 1'b0);
    run_op("ovf_add",  16'h7FFF, 16'h0001, 16'h0000, 1'b0, ALU_ADD, 0, 1'b0);
    run_op("ovf_sub",  16'h8000, 16'h0001, 16'h0000, 1'b0, ALU_SUB, 0, 1'b0);
    run_op("zero",     16'h1234, 16'h1234, 16'h0000, 1'b0, ALU_SUB, 0, 1'b0);
    run_op("held",     16'hBEEF, 16'h1111, 16'h0000, 1'b0, ALU_ADD, 5, 1'b0);
    run_op("retrig",   16'h4000, 16'h4000, 16'h0000, 1'b0, ALU_ADD, 0, 1'b1);
    run_op("scramble", 16'h8001, 16'h0002, 16'h7FFF, 1'b1, ALU_SUB, 1, 1'b1);

    // Reset on the second CALC edge aborts the operation silently.
    @(negedge clk);
    rs1_data  = 16'h0101;
    rs2_data  = 16'h0202;
    alu_op    = ALU_ADD;
    immediate = 1'b0;
    alu_start = 1'b1;
    @(posedge clk);  // E0
    @(posedge clk);  // first CALC edge
    @(negedge clk);
    reset     = 1'b1;
    alu_start = 1'b0;
    @(posedge clk);  // second CALC edge, sampled with reset
    #1;
    chk("midrst.result", alu_result, 0);
    chk("midrst.done", alu_done, 0);
    chk("midrst.flags", {flag_zero, flag_carry, flag_ovf}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst.nopulse%0d", i), alu_done, 0);
    end
    last_res = '0;
    run_op("post_rst", 16'h0F0F, 16'h00F1, 16'h0000, 1'b0, ALU_ADD, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      ri = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, ri, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_alu
`default_nettype wire
